// File: rtl/ldq_alloc_ctrl.sv
// Load queue allocation controller.
// Circular queue bookkeeping in front of the load queue RAM: allocates
// entries in program order at the tail, marks them done from the execute
// pipe, and retires completed entries in order from the head.
module ldq_alloc_ctrl #(
   parameter int DEPTH = 16,
   parameter int INDEX = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             alloc_valid_i,
   input  logic [WIDTH-1:0] alloc_data_i,
   output logic             alloc_ready_o,
   output logic [INDEX-1:0] alloc_id_o,
   input  logic             exec_valid_i,
   input  logic [INDEX-1:0] exec_id_i,
   output logic             commit_ready_o,
   output logic [WIDTH-1:0] commit_data_o,
   input  logic             commit_i,
   input  logic             flush_i,
   output logic [INDEX:0]   count_o,
   output logic             full_o,
   output logic             empty_o,
   output logic             ram_we_o,
   output logic [INDEX-1:0] ram_wr_addr_o,
   output logic [WIDTH-1:0] ram_wr_data_o,
   output logic [INDEX-1:0] ram_rd_addr_o,
   input  logic [WIDTH-1:0] ram_rd_data_i
);

   localparam logic [INDEX:0] FULL_COUNT = (INDEX+1)'(DEPTH);

   logic [INDEX-1:0] head;
   logic [INDEX-1:0] tail;
   logic [INDEX:0]   count;
   logic [DEPTH-1:0] valid;
   logic [DEPTH-1:0] done;

   logic alloc_fire;
   logic exec_fire;
   logic commit_fire;

   assign full_o        = (count == FULL_COUNT);
   assign empty_o       = (count == '0);
   assign count_o       = count;
   assign alloc_ready_o = ~full_o;
   assign alloc_id_o    = tail;

   // The reset term keeps the RAM write enable low while reset is held,
   // even if dispatch keeps presenting a load.
   assign alloc_fire  = alloc_valid_i & alloc_ready_o & ~flush_i & reset;
   assign exec_fire   = exec_valid_i & ~flush_i & valid[exec_id_i];
   assign commit_fire = commit_i & commit_ready_o & ~flush_i;

   assign commit_ready_o = valid[head] & done[head];
   assign commit_data_o  = ram_rd_data_i;
   assign ram_rd_addr_o  = head;

   assign ram_we_o      = alloc_fire;
   assign ram_wr_addr_o = tail;
   assign ram_wr_data_o = alloc_data_i;

   // Queue state: flush and reset both empty the queue; otherwise allocate,
   // complete and retire. The commit clear comes after the execute set so a
   // retiring head entry never stays marked done.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         valid <= '0;
         done  <= '0;
      end else if (flush_i) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         valid <= '0;
         done  <= '0;
      end else begin
         if (alloc_fire) begin
            valid[tail] <= 1'b1;
            done[tail]  <= 1'b0;
            tail        <= tail + INDEX'(1);
         end
         if (exec_fire) begin
            done[exec_id_i] <= 1'b1;
         end
         if (commit_fire) begin
            valid[head] <= 1'b0;
            done[head]  <= 1'b0;
            head        <= head + INDEX'(1);
         end
         case ({alloc_fire, commit_fire})
            2'b10:   count <= count + (INDEX+1)'(1);
            2'b01:   count <= count - (INDEX+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: doc/ldq_alloc_ctrl.md
# ldq_alloc_ctrl

Circular-queue controller for the load queue storage array. Allocates entries in program order at dispatch and writes each load's payload through the array's single write port. Tracks per-entry completion from the load execution pipe and retires completed loads in order from the head, using one array read port. Sits between dispatch/rename, the load execute pipe and the commit stage, directly in front of the load queue RAM.

## Interface
- DEPTH, 16, number of queue entries; always equal to 2**INDEX
- INDEX, 4, entry index width
- WIDTH, 8, payload width stored per entry
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- alloc_valid_i  input  1  dispatch presents a load this cycle
- alloc_data_i  input  WIDTH  payload for the allocated entry
- alloc_ready_o  output  1  queue can accept an allocation this cycle
- alloc_id_o  output  INDEX  index assigned to the current allocation (tail)
- exec_valid_i  input  1  execute pipe reports a completed load
- exec_id_i  input  INDEX  index of the completed load
- commit_ready_o  output  1  head entry is valid and completed
- commit_data_o  output  WIDTH  payload of the head entry
- commit_i  input  1  commit stage retires the head entry
- flush_i  input  1  squash the entire queue (recovery)
- count_o  output  INDEX+1  number of valid entries
- full_o, empty_o  output  1 each  count==DEPTH, count==0
- ram_we_o  output  1  RAM write enable
- ram_wr_addr_o  output  INDEX  RAM write address (tail)
- ram_wr_data_o  output  WIDTH  RAM write data (alloc_data_i)
- ram_rd_addr_o  output  INDEX  RAM read address (head)
- ram_rd_data_i  input  WIDTH  RAM combinational read data

## Operation
- State: head[INDEX-1:0], tail[INDEX-1:0], count[INDEX:0], valid[DEPTH-1:0], done[DEPTH-1:0].
- Allocation: accepted when alloc_valid_i & alloc_ready_o & ~flush_i. On acceptance, ram_we_o=1, ram_wr_addr_o=tail, ram_wr_data_o=alloc_data_i, valid[tail]<=1, done[tail]<=0, tail<=tail+1 (wraps DEPTH-1 -> 0).
- alloc_ready_o = ~full_o, from the registered count only. No same-cycle bypass: a commit in the same cycle does not make a full queue ready.
- alloc_id_o = tail at all times.
- Execute: when exec_valid_i & ~flush_i & valid[exec_id_i], done[exec_id_i]<=1. Execute on an invalid entry is ignored. A repeated execute on a done entry is harmless.
- Commit: commit_ready_o = valid[head] & done[head]. commit_data_o = ram_rd_data_i, ram_rd_addr_o = head.
- Commit is honoured only when commit_i & commit_ready_o & ~flush_i. It clears valid[head] and done[head], and sets head<=head+1 (wraps). commit_i without commit_ready_o is ignored.
- Count: +1 on alloc only, -1 on commit only, unchanged when both or neither occur.
- Flush has highest priority. Next cycle: head=tail=0, count=0, valid=done=0. Same-cycle alloc, exec and commit are ignored, and ram_we_o=0 during flush. RAM contents are not cleared.
- Reset (asynchronous, reset=0): same state as flush. Outputs during and after reset: alloc_ready_o=1, alloc_id_o=0, commit_ready_o=0, empty_o=1, full_o=0, count_o=0, ram_we_o=0, ram_rd_addr_o=0, ram_wr_addr_o=0. Reset asserted mid-operation discards all entries immediately.

## Timing
- ram_we_o, ram_wr_* and commit_ready_o are combinational from registered state and the current inputs. All state changes occur at the rising edge.
- Alloc in cycle N: the RAM is written at the end of N, and the entry is readable at the head from N+1.
- Exec in cycle N: done is set at the end of N, and commit_ready_o rises in N+1 if the entry is at the head.
- Minimum alloc -> commit: alloc N, exec N+1, commit_ready_o N+2.
- Exec and commit on the head entry in the same cycle: commit uses the registered done. If done was 0, no commit occurs and done is set.
- Full queue with simultaneous commit: no allocation; count becomes DEPTH-1 and alloc_ready_o=1 next cycle.

## Test plan
- Reset, then 16 allocs with payloads 0x10..0x1F -> alloc_id_o 0..15, full_o=1 and alloc_ready_o=0 after the 16th; a 17th alloc_valid_i is not written (ram_we_o=0).
- Exec ids 3,1,0 in order, commit_i held high -> commit_ready_o rises on the cycle after exec 0. Payloads 0x10 then 0x11 retire; the queue stalls at head 2 until exec id 2 arrives, then 0x12 and 0x13 retire back-to-back.
- Full queue with head done, alloc_valid_i and commit_i together -> commit occurs, no alloc, count 16->15, alloc_ready_o=1 next cycle.
- Wrap-around: 20 alloc/exec/commit cycles in steady state -> tail and head wrap 15->0, count stays at 1, payload order is preserved.
- flush_i asserted with 5 valid entries plus concurrent alloc, exec and commit -> next cycle count_o=0, empty_o=1, alloc_id_o=0, commit_ready_o=0; ram_we_o=0 in the flush cycle.
- reset dropped asynchronously mid-stream with 7 entries -> outputs take reset values immediately without a clock edge; normal allocation resumes at id 0 after release.
